seg7_mux_counter: RTL and testbench

- Parametrised multi-digit 7-segment counter with a time-multiplexed display drive.
- A prescaler generates a count tick. On each tick a cascaded DIGITS-digit counter (each digit modulo BASE) steps up or down.
- A scan engine cycles one-hot digit enables and drives the matching segment pattern.
- Sits between the top-level pin wrapper (uo_out / uio_out) and user control inputs.

---
 rtl/seg7_mux_counter.sv | 161 ++++++++++++++++
 tb/tb_seg7_mux_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_counter.sv
// Multi-digit BASE-n up/down counter with a prescaled count tick and a
// time-multiplexed 7-segment drive. SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_mux_counter #(
  parameter int TICK_DIV = 10000000,
  parameter int SCAN_DIV = 1000,
  parameter int DIGITS   = 4,
  parameter int BASE     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  wrap_o,
  output logic [6:0]            seg_o,
  output logic [DIGITS-1:0]     dig_en_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    DIG_MAX   = 4'(BASE - 1);
  localparam logic [1:0]    IDX_LAST  = 2'(DIGITS - 1);

  logic [PW-1:0]          presc_q, presc_d;
  logic [4*DIGITS-1:0]    count_q, count_d;
  logic                   wrap_q, wrap_d;
  logic [SW-1:0]          scan_q, scan_d;
  logic [1:0]             idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      dig_q, dig_d;

  logic                   tick;
  logic [4*DIGITS-1:0]    stepped;
  logic                   carry_out;
  logic [3:0]             cur_dig;
  logic                   blank;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'h0: seg_pat = 7'h3F;
      4'h1: seg_pat = 7'h06;
      4'h2: seg_pat = 7'h5B;
      4'h3: seg_pat = 7'h4F;
      4'h4: seg_pat = 7'h66;
      4'h5: seg_pat = 7'h6D;
      4'h6: seg_pat = 7'h7D;
      4'h7: seg_pat = 7'h07;
      4'h8: seg_pat = 7'h7F;
      4'h9: seg_pat = 7'h6F;
      4'hA: seg_pat = 7'h77;
      4'hB: seg_pat = 7'h7C;
      4'hC: seg_pat = 7'h39;
      4'hD: seg_pat = 7'h5E;
      4'hE: seg_pat = 7'h79;
      default: seg_pat = 7'h71;
    endcase
  endfunction

  assign tick = en && (presc_q == PRE_LAST);

  // Full carry/borrow ripple in one cycle; carry_out set means the whole count wrapped.
  always_comb begin
    logic c;
    c       = 1'b1;
    stepped = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (up_dn) begin
          if (count_q[4*i +: 4] == DIG_MAX) stepped[4*i +: 4] = 4'd0;
          else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) stepped[4*i +: 4] = DIG_MAX;
          else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    carry_out = c;
  end

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      presc_d = '0;
      count_d = '0;
    end else if (en) begin
      if (tick) begin
        presc_d = '0;
        count_d = stepped;
        wrap_d  = carry_out;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Display regs sample the current index and count together so they stay aligned.
  always_comb begin
    cur_dig = 4'd0;
    blank   = 1'b0;
    dig_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == 2'(i)) begin
        cur_dig  = count_q[4*i +: 4];
        dig_d[i] = 1'b1;
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = (idx_q != 2'd0);
    for (int i = 0; i < DIGITS; i++) begin
      if ((2'(i) >= idx_q) && (count_q[4*i +: 4] != 4'd0)) blank = 1'b0;
    end
`endif
    seg_d = blank ? 7'h00 : seg_pat(cur_dig);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      seg_q   <= 7'h00;
      dig_q   <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign count_o  = count_q;
  assign wrap_o   = wrap_q;
  assign seg_o    = seg_q;
  assign dig_en_o = dig_q;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Scoreboard bench: integer-arithmetic reference model for three differently
// parameterised instances, compared every cycle, plus targeted spot checks.
module tb_seg7_mux_counter;

  logic clk = 1'b0;
  logic rst_n, en, up_dn, clear;
  always #5 clk = ~clk;

  logic [7:0]  a_cnt; logic a_wrap; logic [6:0] a_seg; logic [1:0] a_dig;
  logic [15:0] b_cnt; logic b_wrap; logic [6:0] b_seg; logic [3:0] b_dig;
  logic [3:0]  c_cnt; logic c_wrap; logic [6:0] c_seg; logic [0:0] c_dig;

  seg7_mux_counter #(.TICK_DIV(4), .SCAN_DIV(2), .DIGITS(2), .BASE(10)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
    .count_o(a_cnt), .wrap_o(a_wrap), .seg_o(a_seg), .dig_en_o(a_dig));
  seg7_mux_counter #(.TICK_DIV(2), .SCAN_DIV(2), .DIGITS(4), .BASE(10)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
    .count_o(b_cnt), .wrap_o(b_wrap), .seg_o(b_seg), .dig_en_o(b_dig));
  seg7_mux_counter #(.TICK_DIV(2), .SCAN_DIV(1), .DIGITS(1), .BASE(6)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
    .count_o(c_cnt), .wrap_o(c_wrap), .seg_o(c_seg), .dig_en_o(c_dig));

  localparam int NI = 3;
  localparam int TD [NI] = '{4, 2, 2};
  localparam int SD [NI] = '{2, 2, 1};
  localparam int DG [NI] = '{2, 4, 1};
  localparam int BS [NI] = '{10, 10, 6};
  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD0 = 7'h00;
`else
  localparam logic [6:0] LEAD0 = 7'h3F;
`endif

  typedef struct {
    logic [15:0] cnt;
    logic        wrap;
    logic [6:0]  seg;
    logic [3:0]  dig;
  } exp_t;

  exp_t sb[$];
  int m_pre [NI], m_val [NI], m_sc [NI], m_idx [NI];
  int n_vec = 0, n_err = 0, a_wraps = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ipow(input int b, input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * b;
    return r;
  endfunction

  function automatic logic [15:0] pack(input int v, input int b, input int n);
    logic [15:0] r = '0;
    for (int k = 0; k < n; k++) r[4*k +: 4] = 4'((v / ipow(b, k)) % b);
    return r;
  endfunction

  // Predict the state after the coming edge from the inputs now applied.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      int dv, d, mm;
      logic blank, tick;
      e.cnt = '0; e.wrap = 1'b0; e.seg = 7'h00; e.dig = 4'h0;
      if (!rst_n) begin
        m_pre[i] = 0; m_val[i] = 0; m_sc[i] = 0; m_idx[i] = 0;
      end else begin
        dv = ipow(BS[i], m_idx[i]);
        d = (m_val[i] / dv) % BS[i];
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank = (m_idx[i] > 0) && (m_val[i] < dv);
`endif
        e.seg = blank ? 7'h00 : PAT[d];
        e.dig = 4'(1 << m_idx[i]);
        if (m_sc[i] == SD[i] - 1) begin
          m_sc[i] = 0;
          m_idx[i] = (m_idx[i] + 1) % DG[i];
        end else m_sc[i]++;
        tick = en && (m_pre[i] == TD[i] - 1);
        mm = ipow(BS[i], DG[i]);
        if (clear) begin
          m_pre[i] = 0; m_val[i] = 0;
        end else if (en) begin
          if (tick) begin
            m_pre[i] = 0;
            if (up_dn) begin
              e.wrap = (m_val[i] == mm - 1);
              m_val[i] = (m_val[i] + 1) % mm;
            end else begin
              e.wrap = (m_val[i] == 0);
              m_val[i] = (m_val[i] == 0) ? mm - 1 : m_val[i] - 1;
            end
          end else m_pre[i]++;
        end
      end
      e.cnt = pack(m_val[i], BS[i], DG[i]);
      sb.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("a_cnt", 16'(a_cnt), e.cnt); chk("a_wrap", 16'(a_wrap), 16'(e.wrap));
    chk("a_seg", 16'(a_seg), 16'(e.seg)); chk("a_dig", 16'(a_dig), 16'(e.dig));
    e = sb.pop_front();
    chk("b_cnt", b_cnt, e.cnt); chk("b_wrap", 16'(b_wrap), 16'(e.wrap));
    chk("b_seg", 16'(b_seg), 16'(e.seg)); chk("b_dig", 16'(b_dig), 16'(e.dig));
    e = sb.pop_front();
    chk("c_cnt", 16'(c_cnt), e.cnt); chk("c_wrap", 16'(c_wrap), 16'(e.wrap));
    chk("c_seg", 16'(c_seg), 16'(e.seg)); chk("c_dig", 16'(c_dig), 16'(e.dig));
    if (a_wrap) a_wraps++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_b_scan(input string tag, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s4, input logic [6:0] s8);
    case (b_dig)
      4'b0001: chk(tag, 16'(b_seg), 16'(s1));
      4'b0010: chk(tag, 16'(b_seg), 16'(s2));
      4'b0100: chk(tag, 16'(b_seg), 16'(s4));
      4'b1000: chk(tag, 16'(b_seg), 16'(s8));
      default: chk({tag, "_onehot"}, 16'(b_dig), 16'h0001);
    endcase
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clear = 1'b0;
    repeat (2) step();
    chk("rst_a_dig", 16'(a_dig), 16'h0);
    chk("rst_b_seg", 16'(b_seg), 16'h0);

    // up-count to wrap; base-6 single digit runs alongside
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1; a_wraps = 0;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (k == 10)  chk("c_at5", 16'(c_cnt), 16'h5);
      if (k == 11)  chk("c_seg5", 16'(c_seg), 16'h6D);
      if (k == 12)  chk("c_wrap0", {11'h0, c_wrap, c_cnt}, 16'h0010);
      if (k == 396) chk("a_at99", 16'(a_cnt), 16'h99);
    end
    chk("a_wrap_once", 16'(a_wraps), 16'd1);
    chk("a_wrapped00", 16'(a_cnt), 16'h00);

    // down-count from zero
    do_reset();
    up_dn = 1'b0; a_wraps = 0;
    for (int k = 1; k <= 364; k++) begin
      step();
      if (k == 4)   chk("dn_99", {7'h0, a_wrap, a_cnt}, 16'h0199);
      if (k == 8)   chk("dn_98", 16'(a_cnt), 16'h98);
      if (k == 360) chk("dn_10", 16'(a_cnt), 16'h10);
      if (k == 364) chk("dn_09", 16'(a_cnt), 16'h09);
    end
    chk("dn_wrap_once", 16'(a_wraps), 16'd1);

    // clear on the tick cycle at 37, then en hold
    do_reset();
    up_dn = 1'b1;
    repeat (151) step();
    chk("pre_clr_37", 16'(a_cnt), 16'h37);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_cnt", {7'h0, a_wrap, a_cnt}, 16'h0000);
    repeat (3) step();
    chk("clr_restart_hold", 16'(a_cnt), 16'h00);
    step();
    chk("clr_restart_tick", 16'(a_cnt), 16'h01);
    repeat (2) step();
    en = 1'b0;
    up_dn = 1'b0;
    repeat (20) step();
    up_dn = 1'b1;
    chk("en_hold", 16'(a_cnt), 16'h01);
    en = 1'b1;
    step();
    chk("en_resume_pre", 16'(a_cnt), 16'h01);
    step();
    chk("en_resume_tick", 16'(a_cnt), 16'h02);

    // scan at 1234
    do_reset();
    repeat (2468) step();
    en = 1'b0;
    chk("b_1234", b_cnt, 16'h1234);
    for (int k = 0; k < 16; k++) begin
      step();
      chk_b_scan("scan1234", 7'h66, 7'h4F, 7'h5B, 7'h06);
    end

    // leading zeros at 0040, then a one-cycle mid-run reset
    do_reset();
    en = 1'b1;
    repeat (80) step();
    en = 1'b0;
    chk("b_0040", b_cnt, 16'h0040);
    for (int k = 0; k < 16; k++) begin
      step();
      chk_b_scan("scan0040", 7'h3F, 7'h66, LEAD0, LEAD0);
    end
    en = 1'b1;
    repeat (5) step();
    do_reset();
    chk("mid_rst_b", {b_seg, 1'b0, b_wrap, 3'b0, b_dig}, 16'h0);
    chk("mid_rst_cnt", b_cnt, 16'h0);

    // randomised en / direction / clear
    for (int k = 0; k < 300; k++) begin
      en = ($urandom_range(0, 3) != 0);
      up_dn = $urandom_range(0, 1) == 1;
      clear = ($urandom_range(0, 19) == 0);
      step();
    end
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
